// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt clock-enable controller for the CPU system top.
// Turns debounced board buttons and the CPU halt flag into a one-cycle clk_en pulse,
// paced in RUN by a programmable divider, driven by single-step presses in PAUSE, and
// held off for good in HALT until the next reset.
module cpu_clk_ctrl #(
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned DEB_CYCLES = 120000,
  parameter bit          START_RUN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             run_btn_i,
  input  logic             step_btn_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             halt_i,
  output logic             clk_en_o,
  output logic             run_o,
  output logic             halted_o,
  output logic             beat_o
);

  // Debounce counter only needs to reach DEB_CYCLES-1; keep at least one bit.
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StPause, StHalt} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic [1:0]       btn_raw;
  logic [1:0]       press;
  logic             run_press;
  logic             step_press;

  // Index 0 is run/pause, index 1 is single-step.
  assign btn_raw    = {step_btn_i, run_btn_i};
  assign run_press  = press[0];
  assign step_press = press[1];

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-FF synchronizer, level debouncer, rising-edge press.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             press_q;
    logic [DEB_W-1:0] cnt_q;

    // Synchronize the raw pin, then accept a new level only after it has been
    // stable for DEB_CYCLES consecutive cycles; flag a press on an accepted rise.
    always_ff @(posedge clk) begin
      if (!reset_n_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          deb_q   <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + DEB_W'(1);
        end
      end
    end

    assign press[gi] = press_q;
  end

  // ---------------------------------------------------------------------------
  // Run-rate divider.
  // ---------------------------------------------------------------------------

  // Using >= rather than == means lowering div_i below the current count wraps
  // on the very next cycle instead of running round the whole counter range.
  assign tick = (div_cnt_q >= div_i);

  // Count only while RUN is being kept; any exit (or staying out) parks it at 0 so
  // that RUN entry always starts a fresh div_i+1 period.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      div_cnt_q <= '0;
    end else if (state_q == StRun && !halt_i && !run_press) begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. Priority: halt > run press > step press.
  // ---------------------------------------------------------------------------

  // State and all outputs update together so run_o/halted_o always match the state.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q  <= START_RUN ? StRun : StPause;
      clk_en_o <= 1'b0;
      run_o    <= START_RUN;
      halted_o <= 1'b0;
      beat_o   <= 1'b0;
    end else begin
      clk_en_o <= 1'b0;
      // Heartbeat follows the pulse by one cycle.
      beat_o   <= beat_o ^ clk_en_o;
      unique case (state_q)
        StRun: begin
          if (halt_i) begin
            state_q  <= StHalt;
            run_o    <= 1'b0;
            halted_o <= 1'b1;
          end else if (run_press) begin
            state_q <= StPause;
            run_o   <= 1'b0;
          end else begin
            // Step presses are deliberately dropped here, not queued.
            clk_en_o <= tick;
          end
        end
        StPause: begin
          if (halt_i) begin
            state_q  <= StHalt;
            halted_o <= 1'b1;
          end else if (run_press) begin
            // A coincident step press is swallowed by the transition.
            state_q <= StRun;
            run_o   <= 1'b1;
          end else if (step_press) begin
            clk_en_o <= 1'b1;
          end
        end
        StHalt: begin
          // Sticky until reset; buttons have no effect.
          halted_o <= 1'b1;
        end
        default: begin
          state_q  <= StPause;
          run_o    <= 1'b0;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized bench for cpu_clk_ctrl against a cycle-level behavioural model.
// The model describes the debouncer as "the last DEB synced samples all disagree
// with the accepted level", with synced samples read from a log of raw pin values.
module tb_cpu_clk_ctrl;

  localparam int unsigned DIV_W     = 8;
  localparam int          DEB       = 4;
  localparam bit          START_RUN = 1'b1;
  localparam int          LOG       = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             run_btn;
  logic             step_btn;
  logic [DIV_W-1:0] div;
  logic             halt;
  logic             clk_en;
  logic             run;
  logic             halted;
  logic             beat;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_W     (DIV_W),
    .DEB_CYCLES(DEB),
    .START_RUN (START_RUN)
  ) u_dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .run_btn_i (run_btn),
    .step_btn_i(step_btn),
    .div_i     (div),
    .halt_i    (halt),
    .clk_en_o  (clk_en),
    .run_o     (run),
    .halted_o  (halted),
    .beat_o    (beat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;   // 0 = RUN, 1 = PAUSE, 2 = HALT
  int unsigned m_phase;  // cycles elapsed in the current RUN period
  bit          m_en;
  bit          m_beat;
  bit          m_deb   [2];
  bit          m_press [2];
  bit          raw_log [2][LOG];
  int          t_edge = 0;
  int          t_rst  = 0;

  // The level seen by the debouncer at edge t is the pin sampled at edge t-2,
  // but only samples taken after the last reset edge are real.
  function automatic bit should_flip(int b, int t);
    int s;
    for (int j = 0; j < DEB; j++) begin
      s = t - j - 2;
      if (s <= t_rst) return 1'b0;
      if (raw_log[b][s % LOG] == m_deb[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit rp;
    bit sp;
    t_edge++;
    raw_log[0][t_edge % LOG] = run_btn;
    raw_log[1][t_edge % LOG] = step_btn;
    if (!reset_n) begin
      t_rst   = t_edge;
      m_mode  = START_RUN ? 0 : 1;
      m_phase = 0;
      m_en    = 1'b0;
      m_beat  = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_deb[b]   = 1'b0;
        m_press[b] = 1'b0;
      end
      return;
    end
    rp     = m_press[0];
    sp     = m_press[1];
    m_beat = m_beat ^ m_en;
    m_en   = 1'b0;
    case (m_mode)
      0: begin
        if (halt) begin
          m_mode  = 2;
          m_phase = 0;
        end else if (rp) begin
          m_mode  = 1;
          m_phase = 0;
        end else if (m_phase >= div) begin
          m_en    = 1'b1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      1: begin
        if (halt) m_mode = 2;
        else if (rp) m_mode = 0;
        else if (sp) m_en = 1'b1;
      end
      default: ;
    endcase
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 1'b0;
      if (should_flip(b, t_edge)) begin
        m_deb[b]   = !m_deb[b];
        m_press[b] = m_deb[b];
      end
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("clk_en_o", 32'(clk_en), 32'(m_en));
    check_eq("run_o",    32'(run),    32'(m_mode == 0));
    check_eq("halted_o", 32'(halted), 32'(m_mode == 2));
    check_eq("beat_o",   32'(beat),   32'(m_beat));
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    reset_n  = 1'b0;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    div      = 8'd3;

    // Reset, then free running at div=3.
    run_n(3);
    reset_n = 1'b1;
    run_n(30);

    // Short glitch on run, then a real press -> PAUSE.
    run_btn = 1'b1; run_n(3);
    run_btn = 1'b0; run_n(10);
    run_btn = 1'b1; run_n(20);
    run_btn = 1'b0; run_n(15);

    // Three clean single steps.
    repeat (3) begin
      step_btn = 1'b1; run_n(8);
      step_btn = 1'b0; run_n(10);
    end

    // Run and step together: back to RUN, no step pulse.
    run_btn  = 1'b1;
    step_btn = 1'b1;
    run_n(8);
    run_btn  = 1'b0;
    step_btn = 1'b0;
    run_n(20);

    // Divisor lowered mid-count, then divide-by-one.
    div = 8'd200; run_n(150);
    div = 8'd10;  run_n(40);
    div = 8'd0;   run_n(10);

    // Halt exactly on a tick cycle, then buttons are ignored until reset.
    div = 8'd5;
    for (int k = 0; k < 30; k++) begin
      if (m_mode == 0 && m_phase >= div) break;
      cycle();
    end
    halt = 1'b1; cycle();
    halt = 1'b0; run_n(5);
    run_btn  = 1'b1; run_n(8);
    run_btn  = 1'b0; run_n(4);
    step_btn = 1'b1; run_n(8);
    step_btn = 1'b0; run_n(4);
    reset_n  = 1'b0; run_n(2);
    reset_n  = 1'b1; run_n(20);

    // Button held through reset: exactly one press once debounced afresh.
    run_btn = 1'b1; run_n(10);
    reset_n = 1'b0; run_n(2);
    reset_n = 1'b1; run_n(12);
    run_btn = 1'b0; run_n(10);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) run_btn = !run_btn;
      if ($urandom_range(0, 9) == 0) step_btn = !step_btn;
      if ($urandom_range(0, 149) == 0) div = 8'($urandom_range(0, 15));
      halt    = ($urandom_range(0, 599) == 0);
      reset_n = !($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
